// File: rtl/mult_rr_arbiter.sv
// Two-requester front end for a shared pipelined multiplier: arbitrates, issues registered
// operands, tracks each op with a tag pipeline and routes products back. MULT_ARB_FIXED_PRIO_EN selects fixed priority.

module mult_rr_rsp_lane #(
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic          hit,
  input  logic [DW-1:0] mul_out,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data
);
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= hit;
      if (hit) rsp_data <= mul_out;
    end
  end
endmodule

module mult_rr_arbiter #(
  parameter int bw  = 4,
  parameter int LAT = 4
) (
  input  logic            CLK,
  input  logic            RESETn,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [bw-1:0]   req0_A,
  input  logic [bw-1:0]   req0_B,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [bw-1:0]   req1_A,
  input  logic [bw-1:0]   req1_B,
  output logic [bw-1:0]   mul_A,
  output logic [bw-1:0]   mul_B,
  input  logic [2*bw-1:0] mul_out,
  output logic            rsp0_valid,
  output logic [2*bw-1:0] rsp0_data,
  output logic            rsp1_valid,
  output logic [2*bw-1:0] rsp1_data,
  output logic            busy
);
  localparam int DW = 2*bw;

  typedef struct packed {
    logic          vld;
    logic [bw-1:0] a;
    logic [bw-1:0] b;
  } req_t;

  req_t [1:0]          req;
  logic [1:0]          gnt;
  logic                accept;
  logic                gnt_id;
  logic [LAT:0]        vld_pipe;
  logic [LAT:0]        id_pipe;
  logic [1:0]          rsp_valid_v;
  logic [1:0][DW-1:0]  rsp_data_v;

  assign req[0] = {req0_valid, req0_A, req0_B};
  assign req[1] = {req1_valid, req1_A, req1_B};

`ifdef MULT_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt[0] = req[0].vld;
    gnt[1] = req[1].vld & ~req[0].vld;
  end
`else
  // last_grant resets to 1 so requester 0 wins the first contested cycle
  logic last_grant;

  always_comb begin
    gnt[0] = req[0].vld & (~req[1].vld |  last_grant);
    gnt[1] = req[1].vld & (~req[0].vld | ~last_grant);
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)     last_grant <= 1'b1;
    else if (accept) last_grant <= gnt_id;
  end
`endif

  assign accept     = |gnt;
  assign gnt_id     = gnt[1];
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      mul_A <= '0;
      mul_B <= '0;
    end else if (accept) begin
      mul_A <= req[gnt_id].a;
      mul_B <= req[gnt_id].b;
    end
  end

  // One extra stage beyond LAT: the response register samples mul_out one edge after it settles
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[LAT-1:0], accept};
      id_pipe  <= {id_pipe[LAT-1:0], gnt_id};
    end
  end

  assign busy = |vld_pipe;

  for (genvar i = 0; i < 2; i++) begin : g_lane
    mult_rr_rsp_lane #(.DW(DW)) u_lane (
      .CLK       (CLK),
      .RESETn    (RESETn),
      .hit       (vld_pipe[LAT] & (id_pipe[LAT] == 1'(i))),
      .mul_out   (mul_out),
      .rsp_valid (rsp_valid_v[i]),
      .rsp_data  (rsp_data_v[i])
    );
  end

  assign rsp0_valid = rsp_valid_v[0];
  assign rsp0_data  = rsp_data_v[0];
  assign rsp1_valid = rsp_valid_v[1];
  assign rsp1_data  = rsp_data_v[1];
endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Directed bench for mult_rr_arbiter with a behavioural LAT-stage multiplier attached.

module tb_mult_rr_arbiter;
  localparam int BW  = 4;
  localparam int LAT = 4;

  logic            CLK, RESETn;
  logic            req0_valid, req0_ready, req1_valid, req1_ready;
  logic [BW-1:0]   req0_A, req0_B, req1_A, req1_B, mul_A, mul_B;
  logic [2*BW-1:0] mul_out, rsp0_data, rsp1_data;
  logic            rsp0_valid, rsp1_valid, busy;
  logic [2*BW-1:0] mp [LAT];

  int checks = 0;
  int errs   = 0;

  mult_rr_arbiter #(.bw(BW), .LAT(LAT)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B),
    .mul_A(mul_A), .mul_B(mul_B), .mul_out(mul_out),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // shared multiplier: LAT register stages from mul_A/mul_B to mul_out
  always_ff @(posedge CLK) begin
    mp[0] <= (2*BW)'(mul_A) * (2*BW)'(mul_B);
    for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
  end
  assign mul_out = mp[LAT-1];

  task automatic do_reset();
    @(negedge CLK);
    RESETn = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge CLK);
    RESETn = 1'b1;
  endtask

  task automatic test_reset();
    RESETn = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_A = '0; req0_B = '0; req1_A = '0; req1_B = '0;
    @(negedge CLK); @(negedge CLK);
    checks++; if ({mul_A, mul_B} !== '0) begin errs++; $display("FAIL reset_mul_ops: got %0d/%0d expected 0/0", mul_A, mul_B); end
    checks++; if ({rsp0_data, rsp1_data} !== '0) begin errs++; $display("FAIL reset_rsp_data: got %0d/%0d expected 0/0", rsp0_data, rsp1_data); end
    checks++; if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin errs++; $display("FAIL reset_valid_busy: got %b expected 000", {rsp0_valid, rsp1_valid, busy}); end
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errs++; $display("FAIL reset_idle_ready: got %b expected 00", {req0_ready, req1_ready}); end
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errs++; $display("FAIL reset_first_winner: got %b expected 10", {req0_ready, req1_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge CLK);
    RESETn = 1'b1;
  endtask

  task automatic test_single();
    @(negedge CLK);
    req0_valid = 1'b1; req0_A = 4'd3; req0_B = 4'd5; #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errs++; $display("FAIL single_ready: got %b expected 10", {req0_ready, req1_ready}); end
    @(negedge CLK);
    req0_valid = 1'b0;
    checks++; if ({mul_A, mul_B, busy} !== {4'd3, 4'd5, 1'b1}) begin errs++; $display("FAIL single_issue: got A=%0d B=%0d busy=%b expected 3 5 1", mul_A, mul_B, busy); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK);
      if (k < 5) begin
        checks++; if ({rsp0_valid, rsp1_valid, busy} !== 3'b001) begin errs++; $display("FAIL single_wait%0d: got %b expected 001", k, {rsp0_valid, rsp1_valid, busy}); end
      end else if (k == 5) begin
        checks++; if ({rsp0_valid, rsp1_valid, busy} !== 3'b100 || rsp0_data !== 8'd15) begin errs++; $display("FAIL single_rsp: got v=%b data=%0d expected 100 15", {rsp0_valid, rsp1_valid, busy}, rsp0_data); end
      end else begin
        checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00 || rsp0_data !== 8'd15) begin errs++; $display("FAIL single_hold: got v=%b data=%0d expected 00 15", {rsp0_valid, rsp1_valid}, rsp0_data); end
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_id [6]  = '{0, 1, 0, 1, 0, 1};
    int exp_val [6] = '{1, 16, 4, 25, 9, 36};
    int ops0 [3] = '{1, 2, 3};
    int ops1 [3] = '{4, 5, 6};
    int i0 = 0, i1 = 0, k;
    do_reset();
    for (int m = 0; m <= 12; m++) begin
      @(negedge CLK);
      k = m - 6;
      if (k >= 0 && k < 6) begin
        checks++;
        if ({rsp0_valid, rsp1_valid} !== (exp_id[k] == 1 ? 2'b01 : 2'b10) ||
            (exp_id[k] == 1 ? rsp1_data : rsp0_data) !== 8'(exp_val[k])) begin
          errs++; $display("FAIL rr_rsp%0d: got v=%b d0=%0d d1=%0d expected id=%0d data=%0d", k, {rsp0_valid, rsp1_valid}, rsp0_data, rsp1_data, exp_id[k], exp_val[k]);
        end
      end else begin
        checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin errs++; $display("FAIL rr_quiet%0d: got %b expected 00", m, {rsp0_valid, rsp1_valid}); end
      end
      if (m < 6) begin
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_A = 4'(ops0[i0 > 2 ? 2 : i0]); req0_B = 4'(ops0[i0 > 2 ? 2 : i0]);
        req1_A = 4'(ops1[i1 > 2 ? 2 : i1]); req1_B = 4'(ops1[i1 > 2 ? 2 : i1]);
        #1;
        checks++; if ({req0_ready, req1_ready} !== (exp_id[m] == 1 ? 2'b01 : 2'b10)) begin errs++; $display("FAIL rr_grant%0d: got %b expected id %0d", m, {req0_ready, req1_ready}, exp_id[m]); end
        if (exp_id[m] == 1) i1++; else i0++;
      end else begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
    end
  endtask

  task automatic test_boundary();
    int opa [3] = '{15, 0, 15};
    int opb [3] = '{15, 7, 1};
    int exp_val [3] = '{225, 0, 15};
    int k;
    for (int m = 0; m <= 9; m++) begin
      @(negedge CLK);
      k = m - 6;
      if (k >= 0 && k < 3) begin
        checks++; if ({rsp0_valid, rsp1_valid} !== 2'b01 || rsp1_data !== 8'(exp_val[k])) begin errs++; $display("FAIL bnd_rsp%0d: got v=%b data=%0d expected 01 %0d", k, {rsp0_valid, rsp1_valid}, rsp1_data, exp_val[k]); end
      end else begin
        checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin errs++; $display("FAIL bnd_quiet%0d: got %b expected 00", m, {rsp0_valid, rsp1_valid}); end
      end
      if (m < 3) begin
        req1_valid = 1'b1; req1_A = 4'(opa[m]); req1_B = 4'(opb[m]); #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errs++; $display("FAIL bnd_grant%0d: got %b expected 01", m, {req0_ready, req1_ready}); end
      end else begin
        req1_valid = 1'b0;
      end
    end
  endtask

  task automatic test_fairness();
    @(negedge CLK);
    req1_valid = 1'b1; req1_A = 4'd1; req1_B = 4'd1; #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errs++; $display("FAIL fair_r1_alone: got %b expected 01", {req0_ready, req1_ready}); end
    @(negedge CLK); req1_valid = 1'b0;
    repeat (3) @(negedge CLK);
    req0_valid = 1'b1; req1_valid = 1'b1; req0_A = 4'd2; req0_B = 4'd2; #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errs++; $display("FAIL fair_after_r1: got %b expected 10", {req0_ready, req1_ready}); end
    req1_valid = 1'b0;
    @(negedge CLK); req0_valid = 1'b0;
    repeat (3) @(negedge CLK);
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errs++; $display("FAIL fair_after_r0: got %b expected 01", {req0_ready, req1_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (8) @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    req0_valid = 1'b1; req0_A = 4'd7; req0_B = 4'd9; #1;
    checks++; if (req0_ready !== 1'b1) begin errs++; $display("FAIL rmid_grant: got %b expected 1", req0_ready); end
    @(negedge CLK); req0_valid = 1'b0;
    @(negedge CLK); RESETn = 1'b0; #1;
    checks++; if ({mul_A, mul_B, rsp0_data, rsp1_data} !== '0) begin errs++; $display("FAIL rmid_data_clear: got A=%0d B=%0d d0=%0d d1=%0d expected all 0", mul_A, mul_B, rsp0_data, rsp1_data); end
    checks++; if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin errs++; $display("FAIL rmid_flags_clear: got %b expected 000", {rsp0_valid, rsp1_valid, busy}); end
    @(negedge CLK); RESETn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      checks++; if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin errs++; $display("FAIL rmid_no_rsp%0d: got %b expected 000", k, {rsp0_valid, rsp1_valid, busy}); end
    end
    req0_valid = 1'b1; req0_A = 4'd2; req0_B = 4'd3;
    @(negedge CLK); req0_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      if (k == 5) begin
        checks++; if ({rsp0_valid, rsp1_valid} !== 2'b10 || rsp0_data !== 8'd6) begin errs++; $display("FAIL rmid_resume: got v=%b data=%0d expected 10 6", {rsp0_valid, rsp1_valid}, rsp0_data); end
      end else begin
        checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin errs++; $display("FAIL rmid_resume_wait%0d: got %b expected 00", k, {rsp0_valid, rsp1_valid}); end
      end
    end
  endtask

  task automatic test_priority();
`ifdef MULT_ARB_FIXED_PRIO_EN
    logic [1:0] exp_g [4] = '{2'b10, 2'b10, 2'b10, 2'b10};
`else
    logic [1:0] exp_g [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
`endif
    do_reset();
    for (int m = 0; m < 4; m++) begin
      @(negedge CLK);
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_A = 4'd1; req0_B = 4'd1; req1_A = 4'd2; req1_B = 4'd2; #1;
      checks++; if ({req0_ready, req1_ready} !== exp_g[m]) begin errs++; $display("FAIL prio_grant%0d: got %b expected %b", m, {req0_ready, req1_ready}, exp_g[m]); end
    end
    @(negedge CLK);
    req0_valid = 1'b0; #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errs++; $display("FAIL prio_r1_alone: got %b expected 01", {req0_ready, req1_ready}); end
    @(negedge CLK); req1_valid = 1'b0;
    repeat (8) @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_boundary();
    test_fairness();
    test_reset_mid();
    test_priority();
    $display("[TB] %0d tests run, %0d failed", checks, errs);
    $finish;
  end
endmodule

// File: doc/mult_rr_arbiter.md
Name: mult_rr_arbiter

Overview:
- Shares one `multiplier_array_pipe` instance between two requesters, using round-robin arbitration.
- Registers the granted operands into the multiplier and carries a requester tag alongside each operation, in a shift pipeline of matching latency.
- Routes each product back to the requester that issued it.
- Sits between the two datapath clients and the shared pipelined multiplier; one operation is issued per cycle at most.

Parameters:
- bw, 4, operand width; products are 2*bw bits.
- LAT, 4, register-stage latency of the shared multiplier: edges from mul_A/mul_B change to mul_out change. Legal range is 1 or more.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESETn  input  1  reset, asynchronous, active-low.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  grant to requester 0 (combinational).
- req0_A  input  bw  requester 0 multiplicand.
- req0_B  input  bw  requester 0 multiplier.
- req1_valid  input  1  requester 1 has an operation.
- req1_ready  output  1  grant to requester 1 (combinational).
- req1_A  input  bw  requester 1 multiplicand.
- req1_B  input  bw  requester 1 multiplier.
- mul_A  output  bw  registered operand to the shared multiplier.
- mul_B  output  bw  registered operand to the shared multiplier.
- mul_out  input  2*bw  product from the shared multiplier.
- rsp0_valid  output  1  one-cycle pulse: rsp0_data holds requester 0's product.
- rsp0_data  output  2*bw  product for requester 0.
- rsp1_valid  output  1  one-cycle pulse: rsp1_data holds requester 1's product.
- rsp1_data  output  2*bw  product for requester 1.
- busy  output  1  high while any accepted operation is still in flight.

Behaviour:
- Reset (asynchronous, RESETn=0): clear mul_A, mul_B, rsp0_data, rsp1_data, rsp0_valid, rsp1_valid, all tag-pipeline valid bits and busy. Set last_grant=1, so requester 0 wins first.
- Handshake:
  - An operation is accepted at a rising edge where reqN_valid=1 and reqN_ready=1.
  - reqN_ready depends only on last_grant and both valids; it never depends on ready of the other side.
  - Requesters must hold A/B stable while valid and not yet ready.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: grant the requester not equal to last_grant.
  - last_grant updates only on an accept. It holds across idle cycles.
- Issue: on accept, load mul_A/mul_B from the granted requester. With no accept, mul_A/mul_B hold their previous values.
- Tag pipeline:
  - Depth LAT+1; each stage holds {valid, id}. Stage 0 loads {accept, granted id} at every edge, and the contents shift every cycle.
  - At the edge where the final stage shows valid, the arbiter registers mul_out into rspN_data for that id and sets rspN_valid=1 for exactly one cycle. The other rsp_valid is 0.
  - rspN_data holds its value until the next response for that id.
- Latency: accept at edge E, product appears on mul_out after edge E+LAT, and rspN_valid is high in the cycle following edge E+LAT+1. Total is LAT+1 cycles.
- Throughput and ordering: one accept per cycle; responses come out in issue order with no reordering. There is no response backpressure; requesters must consume the pulse.
- busy = OR of all tag-stage valid bits.
- Arithmetic: unsigned; product width 2*bw; no overflow is possible.
- Reset mid-operation: all in-flight tags are discarded, and no rsp pulse follows for operations accepted before reset. Resuming after release follows the reset rules above.
- Simultaneous accept and response in the same cycle are independent and both take effect.

Optional Feature:
- Macro MULT_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. Requester 0 wins whenever req0_valid=1, and last_grant is unused.
- Undefined: round-robin as above.
- Latency and response routing are identical in both builds.

Test Plan:
- Single request, bw=4, LAT=4: req0 A=3, B=5 accepted at edge E. Then rsp0_valid=1 for one cycle after edge E+5, rsp0_data=15, and rsp1_valid stays 0. busy is high from after E until the response edge.
- Both valid continuously from reset: grants go 0,1,0,1,0,1. req0 operands 1x1, 2x2, 3x3 and req1 operands 4x4, 5x5, 6x6 give rsp sequence 1(r0), 16(r1), 4(r0), 25(r1), 9(r0), 36(r1) on consecutive cycles.
- Boundary operands: req1 sends 15x15, then 0x7, then 15x1 back-to-back. rsp1_data shows 225, 0, 15 on three consecutive cycles, with rsp0_valid never set.
- Fairness after idle: req1 is granted alone, then 3 idle cycles, then both valid. req0 is granted first.
- Reset mid-flight: accept req0 7x9, then pull RESETn low for 1 cycle 2 edges later. No rsp0_valid follows, and all outputs read 0 during reset. The next req0 2x3 then returns 6 with the normal latency.
- With MULT_ARB_FIXED_PRIO_EN defined and both valid for 4 cycles: all 4 grants go to req0, and req1 is granted on the first cycle req0_valid=0.
